// File: rtl/dma_xfer_engine_if.sv
// Bus master port of the DMA transfer engine.
// Single outstanding request, read data returned on rvalid.
interface dma_xfer_engine_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          valid;
   logic          ready;
   logic          wr;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic          rvalid;
   logic [DW-1:0] rdata;

   modport master (
      output valid, wr, addr, wdata,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, wr, addr, wdata,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/dma_xfer_engine.sv
// DMA transfer engine: moves a job word by word, read then write,
// over a single-outstanding valid/ready bus master port.
module dma_xfer_engine #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int ADDR_STEP  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start_i,
   input  logic                  abort_i,
   input  logic                  dir_i,
   input  logic                  io_fixed_i,
   input  logic [ADDR_WIDTH-1:0] io_addr_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [LEN_WIDTH-1:0]  len_i,
   dma_xfer_engine_if.master     m,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  err_o,
   output logic [LEN_WIDTH-1:0]  words_done_o
);

   typedef enum logic [2:0] {
      IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(ADDR_STEP);

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic                  src_inc_q, dst_inc_q;
   logic [LEN_WIDTH-1:0]  rem_q, wcnt_q;
   logic                  abort_q;
   logic                  valid_q, wr_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  busy_q, done_q, err_q;
   logic [ADDR_WIDTH-1:0] src_d, dst_d;
   logic                  last_d;

   assign src_d  = src_q + (src_inc_q ? STEP : '0);
   assign dst_d  = dst_q + (dst_inc_q ? STEP : '0);
   assign last_d = (rem_q == LEN_WIDTH'(1)) | abort_q | abort_i;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         src_q     <= '0;
         dst_q     <= '0;
         src_inc_q <= 1'b0;
         dst_inc_q <= 1'b0;
         rem_q     <= '0;
         wcnt_q    <= '0;
         abort_q   <= 1'b0;
         valid_q   <= 1'b0;
         wr_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (start_i) begin
                  err_q   <= 1'b0;
                  wcnt_q  <= '0;
                  abort_q <= 1'b0;
                  if (len_i != '0) begin
                     src_q     <= dir_i ? mem_addr_i : io_addr_i;
                     dst_q     <= dir_i ? io_addr_i : mem_addr_i;
                     src_inc_q <= dir_i | ~io_fixed_i;
                     dst_inc_q <= ~dir_i | ~io_fixed_i;
                     rem_q     <= len_i;
                     busy_q    <= 1'b1;
                     valid_q   <= 1'b1;
                     wr_q      <= 1'b0;
                     addr_q    <= dir_i ? mem_addr_i : io_addr_i;
                     state_q   <= RD_REQ;
                  end else begin
                     done_q  <= 1'b1;
                     state_q <= DONE;
                  end
               end
            end
            RD_REQ: begin
               if (abort_i) abort_q <= 1'b1;
               if (m.ready) begin
                  valid_q <= 1'b0;
                  state_q <= RD_WAIT;
               end
            end
            RD_WAIT: begin
               if (abort_i) abort_q <= 1'b1;
               if (m.rvalid) begin
                  wdata_q <= m.rdata;
                  valid_q <= 1'b1;
                  wr_q    <= 1'b1;
                  addr_q  <= dst_q;
                  state_q <= WR_REQ;
               end
            end
            WR_REQ: begin
               if (m.ready) begin
                  wcnt_q <= wcnt_q + LEN_WIDTH'(1);
                  rem_q  <= rem_q - LEN_WIDTH'(1);
                  src_q  <= src_d;
                  dst_q  <= dst_d;
                  // an abort arriving with this handshake still flags err
                  if (last_d) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     err_q   <= abort_q | abort_i;
                     abort_q <= 1'b0;
                     state_q <= DONE;
                  end else begin
                     wr_q    <= 1'b0;
                     addr_q  <= src_d;
                     state_q <= RD_REQ;
                  end
               end else if (abort_i) begin
                  abort_q <= 1'b1;
               end
            end
            DONE: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign m.valid      = valid_q;
   assign m.wr         = wr_q;
   assign m.addr       = addr_q;
   assign m.wdata      = wdata_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;
   assign err_o        = err_q;
   assign words_done_o = wcnt_q;

endmodule

// File: tb/tb_dma_xfer_engine.sv
// Scoreboard bench for dma_xfer_engine: job-level reference model,
// bus slave responder and monitor checking requests and completions.
module tb_dma_xfer_engine;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i, abort_i, dir_i, io_fixed_i;
   logic [31:0] io_addr_i, mem_addr_i;
   logic [15:0] len_i;
   logic        busy_o, done_o, err_o;
   logic [15:0] words_done_o;

   always #5 clk = ~clk;

   dma_xfer_engine_if #(.AW(32), .DW(32)) bus ();

   dma_xfer_engine dut (
      .clk          (clk),
      .reset        (reset),
      .start_i      (start_i),
      .abort_i      (abort_i),
      .dir_i        (dir_i),
      .io_fixed_i   (io_fixed_i),
      .io_addr_i    (io_addr_i),
      .mem_addr_i   (mem_addr_i),
      .len_i        (len_i),
      .m            (bus),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .err_o        (err_o),
      .words_done_o (words_done_o)
   );

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
   } txn_t;

   typedef struct {
      int words;
      bit err;
      bit chkw;
   } res_t;

   txn_t        exp_q[$];
   logic [31:0] data_q[$];
   res_t        res_q[$];

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int rd_seen = 0;
   int jobs_done = 0;
   int done_cyc = 0;
   bit seen_busy = 0;
   int rdy_mode = 0;
   bit rdy_manual = 1;
   int dly_min = 0;
   int dly_max = 0;
   bit spur_en = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h want %0h", name, act, exp);
   endtask

   // Job-level reference: word i reads/writes at base + 4*i per side.
   task automatic model_job(input bit dir, input bit fixed,
                            input logic [31:0] io, input logic [31:0] mem,
                            input int len, input int limit,
                            input bit err, input bit chkw);
      int n;
      logic [31:0] io_a, mem_a;
      txn_t t;
      res_t r;
      n = (limit > 0) ? limit : len;
      for (int i = 0; i < n; i++) begin
         io_a  = io + (fixed ? 32'd0 : 32'(4 * i));
         mem_a = mem + 32'(4 * i);
         t.wr = 1'b0; t.addr = dir ? mem_a : io_a;
         exp_q.push_back(t);
         t.wr = 1'b1; t.addr = dir ? io_a : mem_a;
         exp_q.push_back(t);
      end
      r.words = n; r.err = err; r.chkw = chkw;
      res_q.push_back(r);
   endtask

   // Bus slave + monitor: drives ready/rvalid at negedge, checks requests
   initial begin : monitor
      int   rv_cnt;
      int   stall;
      bit   pend;
      txn_t ptx, e;
      logic [31:0] pdata;
      res_t r;
      rv_cnt = 0; stall = 0; pend = 0;
      bus.ready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0;
      forever begin
         @(negedge clk);
         if (reset) begin
            rv_cnt = 0; stall = 0; pend = 0;
            bus.rvalid = 1'b0; bus.ready = 1'b0;
            continue;
         end
         bus.rvalid = 1'b0;
         if (rv_cnt > 0) begin
            rv_cnt--;
            if (rv_cnt == 0) begin
               bus.rvalid = 1'b1;
               bus.rdata  = $urandom;
               data_q.push_back(bus.rdata);
            end
         end else if (spur_en && $urandom_range(7, 0) == 0) begin
            bus.rvalid = 1'b1;
            bus.rdata  = $urandom;
         end
         case (rdy_mode)
            0: bus.ready = 1'b1;
            1: begin
               if (bus.valid && stall < 5) begin
                  bus.ready = 1'b0; stall++;
               end else begin
                  bus.ready = 1'b1; stall = 0;
               end
            end
            2: bus.ready = ($urandom_range(3, 0) != 0);
            default: bus.ready = rdy_manual;
         endcase
         if (pend) begin
            chk("hold_valid", bus.valid, 1'b1);
            chk("hold_addr", bus.addr, ptx.addr);
            chk("hold_wr", bus.wr, ptx.wr);
            if (ptx.wr) chk("hold_wdata", bus.wdata, pdata);
         end
         pend = bus.valid && !bus.ready;
         ptx.wr = bus.wr; ptx.addr = bus.addr; pdata = bus.wdata;
         if (bus.valid && bus.ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_req: got wr=%0b addr=%h want none",
                        bus.wr, bus.addr);
            end else begin
               e = exp_q.pop_front();
               chk("req_wr", bus.wr, e.wr);
               chk("req_addr", bus.addr, e.addr);
               if (bus.wr) begin
                  if (data_q.size() == 0) begin
                     checks++;
                     $display("FAIL wdata_src: got %h want none", bus.wdata);
                  end else begin
                     chk("wdata", bus.wdata, data_q.pop_front());
                  end
               end else begin
                  rd_seen++;
                  rv_cnt = 1 + $urandom_range(dly_max, dly_min);
               end
            end
         end
         if (busy_o) seen_busy = 1'b1;
         if (done_o) begin
            done_cyc = cyc;
            jobs_done++;
            chk("done_busy", busy_o, 1'b0);
            if (res_q.size() == 0) begin
               checks++;
               $display("FAIL unexpected_done: got 1 want 0");
            end else begin
               r = res_q.pop_front();
               if (r.chkw) chk("words_done", words_done_o, 64'(r.words));
               chk("err", err_o, r.err);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_job(input bit dir, input bit fixed,
                          input logic [31:0] io, input logic [31:0] mem,
                          input int len, input int ab_at,
                          input bit busy_start, output int s);
      int  jd;
      bit  ab;
      model_job(dir, fixed, io, mem, len, ab_at, ab_at > 0, len > 0);
      rd_seen = 0; jd = jobs_done; ab = 0;
      dir_i = dir; io_fixed_i = fixed;
      io_addr_i = io; mem_addr_i = mem; len_i = 16'(len);
      start_i = 1'b1; s = cyc;
      tick();
      start_i = 1'b0;
      io_addr_i = $urandom; mem_addr_i = $urandom;
      dir_i = ~dir; io_fixed_i = ~fixed;
      for (int t = 0; t < 4000 && jobs_done == jd; t++) begin
         start_i = busy_start && (t == 1);
         if (start_i) len_i = 16'd5;
         abort_i = 1'b0;
         if (ab_at > 0 && !ab && rd_seen == ab_at) begin
            abort_i = 1'b1; ab = 1;
         end
         tick();
      end
      start_i = 1'b0; abort_i = 1'b0;
      if (jobs_done == jd) begin
         checks++;
         $display("FAIL job_timeout: got no done want done");
      end
   endtask

   initial begin : stim
      int s, jd;
      bit d, f;
      logic [31:0] io, mem;
      int len, ab;
      reset = 1'b1; start_i = 0; abort_i = 0; dir_i = 0;
      io_fixed_i = 0; io_addr_i = 0; mem_addr_i = 0; len_i = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", bus.valid, 0);
      chk("rst_wr", bus.wr, 0);
      chk("rst_addr", bus.addr, 0);
      chk("rst_wdata", bus.wdata, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_done", done_o, 0);
      chk("rst_err", err_o, 0);
      chk("rst_words", words_done_o, 0);
      reset = 1'b0;
      tick();

      run_job(0, 1, 32'h1000, 32'h2000, 4, 0, 0, s);
      chk("basic_done_cyc", 64'(done_cyc - s), 13);
      repeat (2) tick();
      chk("basic_words_hold", words_done_o, 4);
      chk("basic_err_hold", err_o, 0);

      rdy_mode = 1;
      run_job(1, 0, 32'h8000, 32'h9000, 3, 0, 0, s);
      rdy_mode = 0;

      seen_busy = 0;
      run_job(0, 0, 32'h100, 32'h200, 0, 0, 0, s);
      chk("zero_done_cyc", 64'(done_cyc - s), 1);
      chk("zero_busy", seen_busy, 0);

      run_job(0, 1, 32'hA000, 32'hB000, 8, 2, 0, s);
      repeat (3) tick();
      chk("abort_err_sticky", err_o, 1);
      chk("abort_words_hold", words_done_o, 2);

      run_job(0, 0, 32'h40, 32'hFFFF_FFFC, 2, 0, 0, s);
      chk("wrap_err_cleared", err_o, 0);

      // abort arriving on the same edge as the final write handshake
      rdy_mode = 3; rdy_manual = 1;
      model_job(0, 0, 32'hC000, 32'hD000, 1, 0, 1, 1);
      rd_seen = 0; jd = jobs_done;
      dir_i = 0; io_fixed_i = 0; io_addr_i = 32'hC000;
      mem_addr_i = 32'hD000; len_i = 16'd1; start_i = 1;
      tick();
      start_i = 0;
      for (int t = 0; t < 100 && rd_seen < 1; t++) tick();
      rdy_manual = 0;
      for (int t = 0; t < 100 && !(bus.valid && bus.wr); t++) tick();
      abort_i = 1; rdy_manual = 1;
      tick();
      abort_i = 0;
      for (int t = 0; t < 100 && jobs_done == jd; t++) tick();
      chk("coinc_done_seen", 64'(jobs_done - jd), 1);
      tick();
      rdy_mode = 0;

      // reset while waiting for read data
      dly_min = 5; dly_max = 5;
      begin
         txn_t t0;
         t0.wr = 1'b0; t0.addr = 32'h3000;
         exp_q.push_back(t0);
      end
      rd_seen = 0; jd = jobs_done;
      dir_i = 0; io_fixed_i = 1; io_addr_i = 32'h3000;
      mem_addr_i = 32'h4000; len_i = 16'd3; start_i = 1;
      tick();
      start_i = 0;
      for (int t = 0; t < 100 && rd_seen < 1; t++) tick();
      chk("rst_mid_read_seen", 64'(rd_seen), 1);
      reset = 1'b1;
      #1;
      chk("rst_mid_valid", bus.valid, 0);
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_done", done_o, 0);
      chk("rst_mid_words", words_done_o, 0);
      @(negedge clk);
      tick();
      reset = 1'b0;
      data_q.delete();
      dly_min = 0; dly_max = 0;
      repeat (3) tick();
      chk("rst_mid_no_done", 64'(jobs_done - jd), 0);
      run_job(0, 0, 32'h5000, 32'h6000, 1, 0, 1, s);
      repeat (3) tick();
      chk("post_rst_idle", busy_o, 0);

      rdy_mode = 2; dly_max = 3; spur_en = 1;
      for (int j = 0; j < 24; j++) begin
         d = 1'($urandom_range(1, 0));
         f = 1'($urandom_range(1, 0));
         io = $urandom & 32'hFFFF_FFFC;
         mem = $urandom & 32'hFFFF_FFFC;
         if ($urandom_range(3, 0) == 0) mem = 32'hFFFF_FFF4;
         len = $urandom_range(6, 0);
         ab = (len > 0 && $urandom_range(3, 0) == 0) ?
              $urandom_range(len, 1) : 0;
         run_job(d, f, io, mem, len, ab, 0, s);
      end
      spur_en = 0;
      repeat (5) tick();

      chk("exp_q_empty", 64'(exp_q.size()), 0);
      chk("res_q_empty", 64'(res_q.size()), 0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
